// File: rtl/nav_position_unit.sv
`default_nettype none
// ============================================================================
// Module      : nav_position_unit
// Description : Per-axis navigation position integrator with a jump drive.
//               Velocity is derived combinationally from a one-hot speed
//               mode. It is integrated into a saturating signed position
//               every cycle while cruising. A jump request charges for
//               CHARGE cycles and then loads a captured target into the
//               position.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1     clock, rising edge
//   rst              in   1     synchronous active-high reset
//   mode_i           in   4     one-hot mode: 0001 stop, 0010 attack,
//                               0100 defense, 1000 stealth
//   speed_i          in   N*K   per-axis signed base speed
//   jump_req_i       in   1     request a jump to jump_position_i
//   jump_position_i  in   N*K   per-axis signed jump target
//   jump_abort_i     in   1     cancel a charging jump
//   velocity_o       out  N*K   per-axis mode-scaled velocity (combinational)
//   position_o       out  N*K   per-axis registered position
//   jump_busy_o      out  1     high while the drive is charging
//   jump_done_o      out  1     one-cycle pulse when a jump lands
//   sat_o            out  N     per-axis saturation flag of the last update
//   mode_err_o       out  1     mode_i is not exactly one-hot (combinational)
// ============================================================================
module nav_position_unit #(
    parameter int K      = 16,
    parameter int N      = 3,
    parameter int CHARGE = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     mode_i,
    input  logic [N*K-1:0] speed_i,
    input  logic           jump_req_i,
    input  logic [N*K-1:0] jump_position_i,
    input  logic           jump_abort_i,
    output logic [N*K-1:0] velocity_o,
    output logic [N*K-1:0] position_o,
    output logic           jump_busy_o,
    output logic           jump_done_o,
    output logic [N-1:0]   sat_o,
    output logic           mode_err_o
);

    localparam int CW = (CHARGE > 1) ? $clog2(CHARGE) : 1;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(CHARGE - 1);

    localparam logic [0:0] c_ST_CRUISE = 1'b0;
    localparam logic [0:0] c_ST_CHARGE = 1'b1;

    // Divisor selector: 0 gives zero velocity, 1..3 divide speed by 1..3.
    localparam logic [1:0] c_DIV_ZERO = 2'd0;
    localparam logic [1:0] c_DIV_ONE  = 2'd1;
    localparam logic [1:0] c_DIV_TWO  = 2'd2;
    localparam logic [1:0] c_DIV_THR  = 2'd3;

    localparam logic signed [K-1:0] c_TWO   = K'(2);
    localparam logic signed [K-1:0] c_THREE = K'(3);
    localparam logic [K-1:0] c_POS_MAX = {1'b0, {(K-1){1'b1}}};
    localparam logic [K-1:0] c_NEG_MIN = {1'b1, {(K-1){1'b0}}};

    logic [0:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N*K-1:0] tgt_q, tgt_d;
    logic [N*K-1:0] pos_q, pos_d;
    logic           done_q, done_d;
    logic [N-1:0]   sat_q, sat_d;

    logic [1:0]     w_div;
    logic           w_mode_err;
    logic [N*K-1:0] w_vel;
    logic [N*K-1:0] w_integ;
    logic [N-1:0]   w_clamp;

    // ------------------------------------------------------------------
    // Mode decode: anything other than exactly one bit set is an error
    // and forces zero velocity.
    // ------------------------------------------------------------------
    always_comb begin
        w_div      = c_DIV_ZERO;
        w_mode_err = 1'b0;
        case (mode_i)
            4'b0001: w_div = c_DIV_ZERO;
            4'b0010: w_div = c_DIV_ONE;
            4'b0100: w_div = c_DIV_TWO;
            4'b1000: w_div = c_DIV_THR;
            default: w_mode_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-axis velocity and saturating integration
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N; i++) begin : g_axis
            logic signed [K-1:0] w_spd;
            logic signed [K-1:0] w_v;
            logic [K-1:0]        w_p;
            logic [K:0]          w_sum;
            logic                w_hi;
            logic                w_lo;

            assign w_spd = speed_i[i*K +: K];
            assign w_p   = pos_q[i*K +: K];

            // Signed division truncates toward zero.
            always_comb begin
                w_v = '0;
                case (w_div)
                    c_DIV_ONE: w_v = w_spd;
                    c_DIV_TWO: w_v = w_spd / c_TWO;
                    c_DIV_THR: w_v = w_spd / c_THREE;
                    default:   w_v = '0;
                endcase
            end

            // Sign-extended K+1 bit sum; the top two bits disagree only on
            // overflow, and the carry-out bit gives the overflow direction.
            assign w_sum = {w_p[K-1], w_p} + {w_v[K-1], w_v};
            assign w_hi  = ~w_sum[K] &  w_sum[K-1];
            assign w_lo  =  w_sum[K] & ~w_sum[K-1];

            assign w_vel[i*K +: K]   = w_v;
            assign w_integ[i*K +: K] = w_hi ? c_POS_MAX :
                                       w_lo ? c_NEG_MIN : w_sum[K-1:0];
            assign w_clamp[i]        = w_hi | w_lo;
        end
    endgenerate

    // ------------------------------------------------------------------
    // CRUISE / CHARGE state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        sat_d   = '0;
        case (state_q)
            c_ST_CRUISE: begin
                if (jump_req_i) begin
                    state_d = c_ST_CHARGE;
                    tgt_d   = jump_position_i;
                    cnt_d   = c_CNT_LOAD;
                end else begin
                    pos_d = w_integ;
                    sat_d = w_clamp;
                end
            end
            c_ST_CHARGE: begin
                // Abort takes priority over a landing in the same cycle.
                if (jump_abort_i) begin
                    state_d = c_ST_CRUISE;
                end else if (cnt_q == '0) begin
                    state_d = c_ST_CRUISE;
                    pos_d   = tgt_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = c_ST_CRUISE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_CRUISE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign velocity_o  = w_vel;
    assign position_o  = pos_q;
    assign jump_busy_o = (state_q == c_ST_CHARGE);
    assign jump_done_o = done_q;
    assign sat_o       = sat_q;
    assign mode_err_o  = w_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_nav_position_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_nav_position_unit
// Description : Self-checking bench for nav_position_unit (K=16, N=3,
//               CHARGE=4): directed vector table, hand sequences for
//               saturation and reset-during-charge, then random stimulus
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nav_position_unit;

    localparam int K      = 16;
    localparam int N      = 3;
    localparam int CHARGE = 4;

    logic           clk;
    logic           rst;
    logic [3:0]     mode_i;
    logic [N*K-1:0] speed_i;
    logic           jump_req_i;
    logic [N*K-1:0] jump_position_i;
    logic           jump_abort_i;
    logic [N*K-1:0] velocity_o;
    logic [N*K-1:0] position_o;
    logic           jump_busy_o;
    logic           jump_done_o;
    logic [N-1:0]   sat_o;
    logic           mode_err_o;

    int n_checks = 0;
    int n_errors = 0;

    nav_position_unit #(.K(K), .N(N), .CHARGE(CHARGE)) dut (
        .clk             (clk),
        .rst             (rst),
        .mode_i          (mode_i),
        .speed_i         (speed_i),
        .jump_req_i      (jump_req_i),
        .jump_position_i (jump_position_i),
        .jump_abort_i    (jump_abort_i),
        .velocity_o      (velocity_o),
        .position_o      (position_o),
        .jump_busy_o     (jump_busy_o),
        .jump_done_o     (jump_done_o),
        .sat_o           (sat_o),
        .mode_err_o      (mode_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit       rst;
        bit [3:0] mode;
        int       sx, sy, sz;
        bit       req;
        int       jp;
        bit       ab;
        int       ex, ey, ez;
        int       vx, vy, vz;
        bit       busy;
        bit       done;
        bit [2:0] sat;
    } vec_t;

    // ---------------- helpers ----------------
    function automatic int pos_ax(int i);
        logic signed [15:0] t;
        t = position_o[i*16 +: 16];
        return int'(t);
    endfunction

    function automatic int vel_ax(int i);
        logic signed [15:0] t;
        t = velocity_o[i*16 +: 16];
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [3:0] m, input int sx, input int sy,
                         input int sz, input bit rq, input int jx, input int jy,
                         input int jz, input bit ab);
        rst             = r;
        mode_i          = m;
        speed_i         = {16'(sz), 16'(sy), 16'(sx)};
        jump_req_i      = rq;
        jump_position_i = {16'(jz), 16'(jy), 16'(jx)};
        jump_abort_i    = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int z);
        chk({tag, " pos.x"}, pos_ax(0), x);
        chk({tag, " pos.y"}, pos_ax(1), y);
        chk({tag, " pos.z"}, pos_ax(2), z);
    endtask

    task automatic chk_vel(input string tag, input int x, input int y, input int z);
        chk({tag, " vel.x"}, vel_ax(0), x);
        chk({tag, " vel.y"}, vel_ax(1), y);
        chk({tag, " vel.z"}, vel_ax(2), z);
    endtask

    // ---------------- behavioural reference model ----------------
    int       m_pos[3];
    int       m_tgt[3];
    bit       m_charging;
    int       m_edges_left;
    bit       m_done;
    bit [2:0] m_sat;

    function automatic int model_vel(bit [3:0] m, int s);
        case (m)
            4'b0010: return s;
            4'b0100: return s / 2;
            4'b1000: return s / 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_mode_err(bit [3:0] m);
        return !(m == 4'b0001 || m == 4'b0010 || m == 4'b0100 || m == 4'b1000);
    endfunction

    task automatic model_edge(input bit r, input bit [3:0] m, input int spd[3],
                              input bit rq, input int jp[3], input bit ab);
        int s;
        m_done = 1'b0;
        m_sat  = 3'b000;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_pos[i] = 0;
                m_tgt[i] = 0;
            end
            m_charging   = 1'b0;
            m_edges_left = 0;
        end else if (!m_charging) begin
            if (rq) begin
                m_charging   = 1'b1;
                m_edges_left = CHARGE;
                for (int i = 0; i < 3; i++) m_tgt[i] = jp[i];
            end else begin
                for (int i = 0; i < 3; i++) begin
                    s = m_pos[i] + model_vel(m, spd[i]);
                    if (s > 32767) begin
                        s = 32767;
                        m_sat[i] = 1'b1;
                    end else if (s < -32768) begin
                        s = -32768;
                        m_sat[i] = 1'b1;
                    end
                    m_pos[i] = s;
                end
            end
        end else begin
            if (ab) begin
                m_charging = 1'b0;
            end else begin
                m_edges_left--;
                if (m_edges_left == 0) begin
                    for (int i = 0; i < 3; i++) m_pos[i] = m_tgt[i];
                    m_done     = 1'b1;
                    m_charging = 1'b0;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[$];

    initial begin
        int spd[3];
        int jp[3];
        bit [3:0] m;
        bit r, rq, ab;
        logic signed [15:0] r16;

        drive(1'b1, 4'b0001, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);

        // ---- directed vector table ----
        tbl.push_back('{1'b1, 4'b0010, 1, 1, 1, 1'b0, 0, 1'b0, 0, 0, 0, 1, 1, 1, 1'b0, 1'b0, 3'b000});
        for (int k = 1; k <= 5; k++)
            tbl.push_back('{1'b0, 4'b0010, 1, 1, 1, 1'b0, 0, 1'b0, k, k, k, 1, 1, 1, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b1000, 7, -7, 9, 1'b0, 0, 1'b0, 7, 3, 8, 2, -2, 3, 1'b0, 1'b0, 3'b000});
        // jump to 100: request edge, two idle, re-request (ignored), landing
        tbl.push_back('{1'b0, 4'b0001, 7, -7, 9, 1'b1, 100, 1'b0, 7, 3, 8, 0, 0, 0, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0001, 7, -7, 9, 1'b0, 0, 1'b0, 7, 3, 8, 0, 0, 0, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0001, 7, -7, 9, 1'b1, 200, 1'b0, 7, 3, 8, 0, 0, 0, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0001, 7, -7, 9, 1'b0, 0, 1'b0, 7, 3, 8, 0, 0, 0, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0001, 7, -7, 9, 1'b0, 0, 1'b0, 100, 100, 100, 0, 0, 0, 1'b0, 1'b1, 3'b000});
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b0, 101, 102, 103, 1, 2, 3, 1'b0, 1'b0, 3'b000});
        // abort two edges into the charge
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b1, -50, 1'b0, 101, 102, 103, 1, 2, 3, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b0, 101, 102, 103, 1, 2, 3, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b1, 101, 102, 103, 1, 2, 3, 1'b0, 1'b0, 3'b000});
        // abort while cruising has no effect
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b1, 102, 104, 106, 1, 2, 3, 1'b0, 1'b0, 3'b000});
        // abort coincident with the landing cycle
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b1, -50, 1'b0, 102, 104, 106, 1, 2, 3, 1'b1, 1'b0, 3'b000});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b0, 102, 104, 106, 1, 2, 3, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b1, 102, 104, 106, 1, 2, 3, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 4'b0010, 1, 2, 3, 1'b0, 0, 1'b0, 103, 106, 109, 1, 2, 3, 1'b0, 1'b0, 3'b000});

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].rst, tbl[i].mode, tbl[i].sx, tbl[i].sy, tbl[i].sz,
                  tbl[i].req, tbl[i].jp, tbl[i].jp, tbl[i].jp, tbl[i].ab);
            tick();
            chk_pos(tag, tbl[i].ex, tbl[i].ey, tbl[i].ez);
            chk_vel(tag, tbl[i].vx, tbl[i].vy, tbl[i].vz);
            chk({tag, " busy"}, int'(jump_busy_o), int'(tbl[i].busy));
            chk({tag, " done"}, int'(jump_done_o), int'(tbl[i].done));
            chk({tag, " sat"},  int'(sat_o),       int'(tbl[i].sat));
        end

        // ---- saturation at both rails ----
        drive(1'b0, 4'b0001, 0, 0, 0, 1'b1, 32760, -32760, 0, 1'b0);
        tick();
        drive(1'b0, 4'b0001, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        repeat (CHARGE) tick();
        chk_pos("sat-land", 32760, -32760, 0);
        chk("sat-land done", int'(jump_done_o), 1);
        drive(1'b0, 4'b0010, 16, -16, 0, 1'b0, 0, 0, 0, 1'b0);
        tick();
        chk_pos("sat1", 32767, -32768, 0);
        chk_vel("sat1", 16, -16, 0);
        chk("sat1 sat", int'(sat_o), 3);
        drive(1'b0, 4'b0010, 16, -16, 5, 1'b0, 0, 0, 0, 1'b0);
        tick();
        chk_pos("sat2", 32767, -32768, 5);
        chk("sat2 sat", int'(sat_o), 3);
        drive(1'b0, 4'b0010, -1, 1, 0, 1'b0, 0, 0, 0, 1'b0);
        tick();
        chk_pos("sat3", 32766, -32767, 5);
        chk("sat3 sat", int'(sat_o), 0);

        // ---- reset in the middle of a charge, with an invalid mode ----
        drive(1'b0, 4'b0101, 9, 9, 9, 1'b1, 100, 100, 100, 1'b0);
        tick();
        chk("rstchg busy E", int'(jump_busy_o), 1);
        chk("rstchg mode_err", int'(mode_err_o), 1);
        chk_vel("rstchg", 0, 0, 0);
        drive(1'b0, 4'b0101, 9, 9, 9, 1'b0, 0, 0, 0, 1'b0);
        tick();
        drive(1'b1, 4'b0101, 9, 9, 9, 1'b1, 100, 100, 100, 1'b1);
        tick();
        chk_pos("rstchg", 0, 0, 0);
        chk("rstchg busy", int'(jump_busy_o), 0);
        chk("rstchg done", int'(jump_done_o), 0);
        chk("rstchg sat", int'(sat_o), 0);
        chk("rstchg err@rst", int'(mode_err_o), 1);
        chk_vel("rstchg@rst", 0, 0, 0);
        drive(1'b0, 4'b0101, 9, 9, 9, 1'b0, 0, 0, 0, 1'b0);
        for (int k = 0; k < CHARGE + 1; k++) begin
            tick();
            chk($sformatf("post-rst%0d done", k), int'(jump_done_o), 0);
            chk($sformatf("post-rst%0d busy", k), int'(jump_busy_o), 0);
            chk($sformatf("post-rst%0d pos.x", k), pos_ax(0), 0);
        end

        // ---- random stimulus vs. model ----
        for (int i = 0; i < 3; i++) begin
            spd[i] = 0;
            jp[i]  = 0;
        end
        m = 4'b0001;
        drive(1'b1, m, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        model_edge(1'b1, m, spd, 1'b0, jp, 1'b0);
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pick;
            string tag;
            pick = int'($urandom_range(0, 4));
            m = (pick < 4) ? 4'(1 << pick) : 4'($urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r16 = 16'($urandom);
                    spd[i] = int'(r16);
                end else begin
                    spd[i] = int'($urandom_range(0, 40)) - 20;
                end
                r16   = 16'($urandom);
                jp[i] = int'(r16);
            end
            r  = ($urandom_range(0, 49) == 0);
            rq = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 7) == 0);
            drive(r, m, spd[0], spd[1], spd[2], rq, jp[0], jp[1], jp[2], ab);
            model_edge(r, m, spd, rq, jp, ab);
            tick();
            tag = $sformatf("rnd%0d", cyc);
            chk_pos(tag, m_pos[0], m_pos[1], m_pos[2]);
            chk_vel(tag, model_vel(m, spd[0]), model_vel(m, spd[1]), model_vel(m, spd[2]));
            chk({tag, " busy"}, int'(jump_busy_o), int'(m_charging));
            chk({tag, " done"}, int'(jump_done_o), int'(m_done));
            chk({tag, " sat"},  int'(sat_o),       int'(m_sat));
            chk({tag, " mode_err"}, int'(mode_err_o), int'(model_mode_err(m)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nav_position_unit.md
NAV_POSITION_UNIT -- requirements
Module: nav_position_unit

Interface
REQ-001 Parameter K, default 16: per-axis word width in bits (K >= 4).
REQ-002 Parameter N, default 3: axis count; axis i occupies bits [(i+1)*K-1 : i*K], axis 0 = X, axis 1 = Y, axis 2 = Z.
REQ-003 Parameter CHARGE, default 8: jump-drive charge cycles (CHARGE >= 1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 mode  input  4  one-hot speed mode: 0001 stop, 0010 attack, 0100 defense, 1000 stealth.
REQ-007 speed  input  N*K  per-axis base speed, signed two's complement.
REQ-008 jump_req  input  1  request a jump to jump_position.
REQ-009 jump_position  input  N*K  per-axis jump target, signed.
REQ-010 jump_abort  input  1  cancel a jump that is charging.
REQ-011 velocity  output  N*K  per-axis mode-scaled velocity, signed, combinational.
REQ-012 position  output  N*K  per-axis position, signed, registered.
REQ-013 jump_busy  output  1  high while in CHARGE.
REQ-014 jump_done  output  1  one-cycle pulse: the jump has landed.
REQ-015 sat  output  N  per-axis flag: that axis saturated on the last update.
REQ-016 mode_err  output  1  combinational: mode is not exactly one-hot.

Function
REQ-017 Velocity per axis SHALL be speed/1 (attack), speed/2 (defense), speed/3 (stealth) or 0 (stop), each quotient truncated toward zero.
REQ-018 A non-one-hot mode (including 0000) SHALL give velocity 0 on all axes and raise mode_err.
REQ-019 The FSM SHALL have two states: CRUISE and CHARGE.
REQ-020 In CRUISE, each clock edge SHALL set position to position + velocity per axis, computed at K+1 bits.
REQ-021 That sum SHALL saturate to +(2^(K-1)-1) or -(2^(K-1)), with no wrap-around.
REQ-022 A clamped axis SHALL have its sat bit set for that cycle; otherwise its sat bit SHALL be 0.
REQ-023 A mode or speed change SHALL first affect position at the next clock edge.
REQ-024 jump_req high in CRUISE SHALL, on that edge: enter CHARGE, capture jump_position into a target register, load the counter with CHARGE-1, and leave position unchanged.
REQ-025 In CHARGE, position SHALL hold; velocity SHALL still be output but not integrated; sat SHALL be 0.
REQ-026 In CHARGE with jump_abort high, the next edge SHALL return to CRUISE with position unchanged and no jump_done.
REQ-027 In CHARGE with counter 0 and no abort, the next edge SHALL load target into position, pulse jump_done for one cycle and return to CRUISE.
REQ-028 In CHARGE with counter nonzero and no abort, the counter SHALL decrement.
REQ-029 Landing SHALL occur exactly CHARGE edges after the request edge.
REQ-030 jump_req while in CHARGE SHALL be ignored; the target SHALL NOT be recaptured.
REQ-031 jump_abort in CRUISE SHALL have no effect.
REQ-032 Abort and counter 0 in the same cycle: abort SHALL win.
REQ-033 jump_busy SHALL equal (state == CHARGE).
REQ-034 Integration SHALL resume at the first edge after landing, starting from the target value.

Reset
REQ-035 rst high at an edge SHALL set position = 0 on all axes, state = CRUISE, counter = 0, target = 0, jump_busy = 0, jump_done = 0, sat = 0.
REQ-036 rst SHALL override jump_req, jump_abort and integration in the same cycle.
REQ-037 rst during CHARGE SHALL cancel the jump with no jump_done.
REQ-038 velocity and mode_err SHALL depend only on mode and speed, not on rst.

Verification (K=16, N=3, CHARGE=4)
REQ-039 rst, then mode=0010, speed=1/1/1 for 5 edges -> position 5/5/5; sat=000.
REQ-040 Position 5/5/5, mode=1000, speed=7/-7/9 for 1 edge -> velocity 2/-2/3; position 7/3/8.
REQ-041 jump_req with target 100/100/100 at edge E -> jump_busy high E..E+3; position 100/100/100 and jump_done=1 after edge E+4; jump_req at E+2 ignored.
REQ-042 Abort at E+2, then abort coincident with counter 0 (separate runs) -> no jump_done; position unchanged; back to CRUISE.
REQ-043 Position X=32760, speed X=16, attack -> X=32767, sat[0]=1; negative mirror -> -32768.
REQ-044 rst at E+2 of a charge with mode=0101 -> all registers 0, no jump_done, mode_err=1, velocity 0.
